// File: rtl/bsk_prm.sv
// bsk_prm: bus-mapped command register pair with test readback.
// Drives active-low command/indication lines and a terminal enable.
module bsk_prm #(
  parameter logic [5:0] VERSION  = 6'h24,
  parameter logic [7:0] PASSWORD = 8'hA6,
  parameter logic [3:0] CS       = 4'b0111
) (
  input  logic        iClk,
  input  logic        iRes,
  inout  wire  [15:0] bD,
  input  logic        iRd,
  input  logic        iWr,
  input  logic        iBl,
  input  logic        iKEnable,
  input  logic [1:0]  iA,
  input  logic [3:0]  iCS,
  input  logic [15:0] iComT,
  output logic [15:0] oCom,
  output logic [15:0] oComInd,
  output logic        oCS,
  output logic        oEnable
);

  localparam logic [1:0] A_TEST = 2'd0;
  localparam logic [1:0] A_COM  = 2'd1;
  localparam logic [1:0] A_IND  = 2'd2;
  localparam logic [1:0] A_ID   = 2'd3;

  logic        sel;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] rd_data;
  logic [15:0] com_q, com_d;
  logic [15:0] ind_q, ind_d;

  assign sel   = (iCS == CS);
  assign oCS   = ~sel;
  // a low read strobe always wins over a pending write
  assign rd_en = sel & ~iRd;
  assign wr_en = sel & ~iWr & iRd;

  // read mux: purely combinational, independent of reset and iWr
  always_comb begin
    rd_data = '0;
    unique case (iA)
      A_TEST: rd_data = iComT;
      A_COM:  rd_data = com_q;
      A_IND:  rd_data = ind_q;
      A_ID:   rd_data = {PASSWORD, VERSION, iKEnable, ~iBl};
      default: rd_data = '0;
    endcase
  end

  assign bD = rd_en ? rd_data : 16'hzzzz;

  // next-state decode: only COM and IND are writable
  always_comb begin
    com_d = com_q;
    ind_d = ind_q;
    if (wr_en) begin
      unique case (iA)
        A_COM:  com_d = bD;
        A_IND:  ind_d = bD;
        default: ;
      endcase
    end
  end

  // register update; reset clears and holds both registers
  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      com_q <= '0;
      ind_q <= '0;
    end else begin
      com_q <= com_d;
      ind_q <= ind_d;
    end
  end

  assign oComInd = ~ind_q;
  assign oCom    = iBl ? ~com_q : 16'hFFFF;
  assign oEnable = ~(iRes & iBl & iKEnable);

endmodule

// File: tb/tb_bsk_prm.sv
// tb_bsk_prm: scoreboard bench for bsk_prm.
// Expected values are queued at stimulus time and popped at sampling.
module tb_bsk_prm;

  localparam logic [3:0] CS = 4'b0111;

  logic        iClk = 1'b0;
  logic        iRes, iRd, iWr, iBl, iKEnable;
  logic [1:0]  iA;
  logic [3:0]  iCS;
  logic [15:0] iComT;
  logic [15:0] oCom, oComInd;
  logic        oCS, oEnable;
  logic        drv_en;
  logic [15:0] drv_val;
  wire  [15:0] bD;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] com_m, ind_m;

  always #5 iClk = ~iClk;

  assign bD = drv_en ? drv_val : 16'hzzzz;

  bsk_prm dut (
    .iClk(iClk), .iRes(iRes), .bD(bD), .iRd(iRd), .iWr(iWr),
    .iBl(iBl), .iKEnable(iKEnable), .iA(iA), .iCS(iCS),
    .iComT(iComT), .oCom(oCom), .oComInd(oComInd),
    .oCS(oCS), .oEnable(oEnable)
  );

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [15:0] rd_model(input logic [1:0] a);
    logic [15:0] r;
    case (a)
      2'd0: r = iComT;
      2'd1: r = com_m;
      2'd2: r = ind_m;
      default: r = {8'hA6, 6'h24, iKEnable, ~iBl};
    endcase
    return r;
  endfunction

  task automatic rd(input logic [1:0] a, input string tag);
    drv_en = 1'b0;
    iCS = CS;
    iA = a;
    iRd = 1'b0;
    #1;
    push(rd_model(a));
    chk(tag, bD);
    iRd = 1'b1;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] v,
                    input logic rdn);
    @(negedge iClk);
    iCS = CS;
    iA = a;
    drv_val = v;
    drv_en = 1'b1;
    iRd = rdn;
    iWr = 1'b0;
    @(posedge iClk);
    #1;
    iWr = 1'b1;
    iRd = 1'b1;
    drv_en = 1'b0;
    if (iRes && rdn) begin
      if (a == 2'd1) com_m = v;
      if (a == 2'd2) ind_m = v;
    end
  endtask

  task automatic chk_outs(input string tag);
    #1;
    push(iBl ? ~com_m : 16'hFFFF);
    chk({tag, "_com"}, oCom);
    push(~ind_m);
    chk({tag, "_ind"}, oComInd);
    push({15'd0, ~(iRes & iBl & iKEnable)});
    chk({tag, "_en"}, {15'd0, oEnable});
  endtask

  initial begin
    logic [3:0] cs_tab [4];
    logic [15:0] v;
    cs_tab = '{4'b0000, 4'b1111, 4'b0111, 4'b1111};
    com_m = '0;
    ind_m = '0;
    iRes = 1'b0; iRd = 1'b1; iWr = 1'b1; iBl = 1'b0;
    iKEnable = 1'b0; iA = '0; iCS = '0; iComT = '0;
    drv_en = 1'b0; drv_val = '0;
    #12;

    chk_outs("rst");

    foreach (cs_tab[i]) begin
      iCS = cs_tab[i];
      #1;
      push({15'd0, cs_tab[i] != CS});
      chk($sformatf("ocs%0d", i), {15'd0, oCS});
    end

    iComT = 16'h1331;
    iKEnable = 1'b1;
    iBl = 1'b0;
    for (int a = 0; a < 4; a++) rd(2'(a), $sformatf("rst_rd%0d", a));
    wr(2'd1, 16'h1234, 1'b1);
    wr(2'd2, 16'h4321, 1'b1);
    chk_outs("rst_wr");
    rd(2'd1, "rst_wr_com");

    @(negedge iClk);
    iRes = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a), $sformatf("rd%0d", a));
    iWr = 1'b0;
    for (int a = 0; a < 4; a++) rd(2'(a), $sformatf("wrlo_rd%0d", a));
    @(posedge iClk);
    #1;
    iWr = 1'b1;
    rd(2'd1, "wrlo_nowr");

    iCS = CS; iRd = 1'b1; iA = 2'd0;
    drv_val = 16'h5AA5; drv_en = 1'b1;
    #1;
    push(16'h5AA5);
    chk("ext_rdhi", bD);
    iCS = 4'b0000; iRd = 1'b0; iComT = 16'hA55A;
    #1;
    push(16'h5AA5);
    chk("ext_nocs", bD);
    iRd = 1'b1; drv_en = 1'b0; iComT = 16'h1331;

    iBl = 1'b1;
    wr(2'd2, 16'h9231, 1'b1);
    wr(2'd1, 16'h00F0, 1'b1);
    #1;
    push(16'h6DCE);
    chk("ind_out", oComInd);
    push(16'hFF0F);
    chk("com_out", oCom);
    rd(2'd1, "rb_com");
    rd(2'd2, "rb_ind");
    wr(2'd1, 16'h0F00, 1'b0);
    rd(2'd1, "rdpri_com");
    wr(2'd0, 16'hFFFF, 1'b1);
    wr(2'd3, 16'hFFFF, 1'b1);
    rd(2'd1, "a03_com");
    rd(2'd2, "a03_ind");
    chk_outs("bl1");
    iKEnable = 1'b0;
    chk_outs("ken0");
    iKEnable = 1'b1;

    iBl = 1'b0;
    #1;
    push(16'hFFFF);
    chk("blk_com", oCom);
    push(16'h6DCE);
    chk("blk_ind", oComInd);
    rd(2'd3, "blk_id");
    iBl = 1'b1;
    #1;
    push(16'hFF0F);
    chk("unblk_com", oCom);

    for (int k = 0; k < 4; k++) begin
      v = 16'($urandom);
      wr(2'(1 + (k % 2)), v, 1'b1);
      chk_outs($sformatf("rnd%0d", k));
      rd(2'(1 + (k % 2)), $sformatf("rnd_rb%0d", k));
    end

    wr(2'd1, 16'h5555, 1'b1);
    wr(2'd2, 16'hAAAA, 1'b1);
    @(posedge iClk);
    #2;
    iRes = 1'b0;
    com_m = '0;
    ind_m = '0;
    #1;
    push(16'hFFFF);
    chk("async_com", oCom);
    push(16'hFFFF);
    chk("async_ind", oComInd);
    rd(2'd1, "async_rd1");
    rd(2'd2, "async_rd2");
    chk_outs("async");

    @(negedge iClk);
    iRes = 1'b1;
    wr(2'd1, 16'hABCD, 1'b1);
    rd(2'd1, "post_rst");
    chk_outs("post_rst");

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_left: got %0d entries want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsk_prm.md
BSK_PRM -- requirements
Module: bsk_prm

Interface
REQ-001 Parameter VERSION, default 6'h24, firmware version reported in register 3 bits [7:2].
REQ-002 Parameter PASSWORD, default 8'hA6, identification byte reported in register 3 bits [15:8].
REQ-003 Parameter CS, default 4'b0111, chip-select code that selects this block.
REQ-004 iClk  in  1  system clock; all register writes occur on its rising edge.
REQ-005 iRes  in  1  reset, asynchronous, active-low.
REQ-006 bD  inout  16  bidirectional data bus.
REQ-007 iRd  in  1  read strobe, active-low.
REQ-008 iWr  in  1  write strobe, active-low.
REQ-009 iBl  in  1  block input, active-low (0 = outputs blocked).
REQ-010 iKEnable  in  1  terminal-enable request, active-high.
REQ-011 iA  in  2  register address.
REQ-012 iCS  in  4  chip-select code.
REQ-013 iComT  in  16  command test input.
REQ-014 oCom  out  16  command outputs, active-low.
REQ-015 oComInd  out  16  command indication outputs, active-low.
REQ-016 oCS  out  1  chip-selected indicator, active-low.
REQ-017 oEnable  out  1  terminal enable, active-low.

Function
REQ-018 oCS SHALL be combinational: 0 when iCS == CS, otherwise 1; iCS 4'b0000 and 4'b1111 give 1 for the default CS.
REQ-019 The block SHALL drive bD only when oCS == 0 and iRd == 0; otherwise bD SHALL be 16'hZZZZ.
REQ-020 Read data SHALL be combinational from iA: 0 -> iComT; 1 -> COM register; 2 -> IND register; 3 -> {PASSWORD, VERSION, iKEnable, ~iBl}.
REQ-021 Reads SHALL be unaffected by iRes and iWr; register 3 SHALL read correctly during reset and while iWr == 0.
REQ-022 A write SHALL occur when oCS == 0, iWr == 0 and iRd == 1, and SHALL capture bD on each rising iClk edge while that condition holds.
REQ-023 A write to iA 1 SHALL load COM; a write to iA 2 SHALL load IND; writes to iA 0 and 3 SHALL be ignored.
REQ-024 iRd == 0 SHALL take priority over iWr == 0; no write occurs while iRd is low.
REQ-025 oComInd SHALL equal ~IND, independent of iCS and iBl.
REQ-026 oCom SHALL equal ~COM when iBl == 1; when iBl == 0, oCom SHALL be 16'hFFFF.
REQ-027 oEnable SHALL be 0 only when iRes == 1, iBl == 1 and iKEnable == 1; otherwise 1.
REQ-028 oCom, oComInd, oCS and oEnable SHALL be combinational from registers and inputs.

Reset
REQ-029 iRes == 0 SHALL asynchronously clear COM and IND to 16'h0000 and hold them cleared; writes SHALL be ignored during reset.
REQ-030 During reset: oCom = 16'hFFFF, oComInd = 16'hFFFF, oEnable = 1; oCS and the read path SHALL remain functional.
REQ-031 Registers SHALL leave reset on iRes rising, with the first capture on the next qualifying iClk edge.

Verification
REQ-032 iCS = 0000 / 1111 / 0111 / 1111 -> oCS = 1 / 1 / 0 / 1.
REQ-033 iCS = CS, iRd = 0, iRes = 1, iComT = 16'h1331, iBl = 0, iKEnable = 1, iA = 0..3 -> bD = 16'h1331, 16'h0000, 16'h0000, 16'hA693; bD is unchanged with iRes = 0 or iWr = 0.
REQ-034 iRd = 1 with an external driver on bD -> the external value is seen on bD; iRd = 0 with iCS != CS -> bD = 16'hZZZZ.
REQ-035 iRes = 1, iBl = 1, write 16'h9231 to iA 2 and 16'h00F0 to iA 1 -> oComInd = 16'h6DCE, oCom = 16'hFF0F; read-back returns the written values; a write attempt with iRd = 0 changes nothing.
REQ-036 With COM loaded, iBl = 0 -> oCom = 16'hFFFF and oComInd is unchanged; iBl = 1 -> oCom = ~COM.
REQ-037 Assert iRes = 0 mid-operation, asynchronously with no iClk edge -> oCom = oComInd = 16'hFFFF and iA 1/2 read 16'h0000.
